// File: rtl/conv_layer_ctrl_if.sv
// Handshake and datapath-control bundle between conv_layer_ctrl and its
// memory/MAC datapath. master = controller side, slave = datapath/stream side.
interface conv_layer_ctrl_if #(
    parameter int N = 64,
    parameter int M = 9,
    parameter int P = 8
);
    localparam int AW = $clog2(N);
    localparam int KW = $clog2(M);
    localparam int PW = $clog2(P);

    logic          x_valid;
    logic          x_ready;
    logic          xmem_wr_en;
    logic [AW-1:0] xmem_wr_addr;
    logic          rd_en;
    logic [KW-1:0] rd_k;
    logic [AW-1:0] rd_base;
    logic          mac_en;
    logic          mac_clr;
    logic          out_load;
    logic          y_valid;
    logic          y_ready;
    logic [PW-1:0] y_sel;

    modport master (
        input  x_valid, y_ready,
        output x_ready, xmem_wr_en, xmem_wr_addr, rd_en, rd_k, rd_base,
               mac_en, mac_clr, out_load, y_valid, y_sel
    );

    modport slave (
        output x_valid, y_ready,
        input  x_ready, xmem_wr_en, xmem_wr_addr, rd_en, rd_k, rd_base,
               mac_en, mac_clr, out_load, y_valid, y_sel
    );
endinterface

// File: rtl/conv_layer_ctrl.sv
// Load / compute / drain sequencer for one 1-D convolution layer (no arithmetic).
// Define CONV_CTRL_OVERLAP_EN to overlap the next group's compute with the current drain.
module conv_layer_ctrl #(
    parameter int N = 64,
    parameter int M = 9,
    parameter int P = 8
) (
    input  logic               clk,
    input  logic               reset,
    conv_layer_ctrl_if.master  bus
);
    localparam int NOUT = N - M + 1;
    localparam int AW   = $clog2(N);
    localparam int KW   = $clog2(M);
    localparam int PW   = $clog2(P);
    localparam int TW   = $clog2(M + 3);

    localparam logic [TW-1:0] T_RD_END = TW'(M);
    localparam logic [TW-1:0] T_OUT    = TW'(M + 2);
    localparam logic [AW-1:0] LD_LAST  = AW'(N - 1);
    localparam logic [AW-1:0] STEP     = AW'(P);

    typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ld_cnt_q, ld_cnt_d;
    logic [AW-1:0] base_q, base_d;
    logic [TW-1:0] t_q, t_d;
    logic          comp_act_q, comp_act_d;
    logic [PW-1:0] lane_q, lane_d;
    logic [1:0]    en_pipe_q, en_pipe_d;
    logic [1:0]    clr_pipe_q, clr_pipe_d;

    logic          rd_en_i;
    logic          comp_done;
    logic          x_acc;
    logic          y_acc;
    logic [31:0]   remain;
    logic [31:0]   lanes;
    logic          lane_last;
    logic          has_next;

    always_comb begin
        rd_en_i   = comp_act_q && (t_q < T_RD_END);
        comp_done = comp_act_q && (t_q == T_OUT);
        x_acc     = (state_q == LOAD) && bus.x_valid;
        y_acc     = (state_q == DRAIN) && bus.y_ready;
        remain    = 32'(NOUT) - 32'(base_q);
        lanes     = (remain < 32'(P)) ? remain : 32'(P);
        lane_last = (32'(lane_q) == lanes - 32'd1);
        has_next  = (32'(base_q) + 32'(P)) < 32'(NOUT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= LOAD;
            ld_cnt_q   <= '0;
            base_q     <= '0;
            t_q        <= '0;
            comp_act_q <= 1'b0;
            lane_q     <= '0;
            en_pipe_q  <= '0;
            clr_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            base_q     <= base_d;
            t_q        <= t_d;
            comp_act_q <= comp_act_d;
            lane_q     <= lane_d;
            en_pipe_q  <= en_pipe_d;
            clr_pipe_q <= clr_pipe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        base_d     = base_q;
        t_d        = t_q;
        comp_act_d = comp_act_q;
        lane_d     = lane_q;
        // one cycle for memory read, one for the multiplier register
        en_pipe_d  = {en_pipe_q[0], rd_en_i};
        clr_pipe_d = {clr_pipe_q[0], rd_en_i && (t_q == '0)};

        // t saturates at the out_load slot so an overlapped group can wait there
        if (comp_act_q && (t_q != T_OUT)) begin
            t_d = t_q + 1'b1;
        end

        unique case (state_q)
            LOAD: begin
                if (x_acc) begin
                    if (ld_cnt_q == LD_LAST) begin
                        ld_cnt_d   = '0;
                        base_d     = '0;
                        t_d        = '0;
                        comp_act_d = 1'b1;
                        state_d    = COMPUTE;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                if (comp_done) begin
                    state_d = DRAIN;
`ifdef CONV_CTRL_OVERLAP_EN
                    if (has_next) begin
                        t_d        = '0;
                        comp_act_d = 1'b1;
                    end else begin
                        comp_act_d = 1'b0;
                    end
`else
                    comp_act_d = 1'b0;
`endif
                end
            end
            DRAIN: begin
                if (y_acc) begin
                    if (lane_last) begin
                        lane_d = '0;
                        base_d = base_q + STEP;
                        if (has_next) begin
                            state_d = COMPUTE;
`ifndef CONV_CTRL_OVERLAP_EN
                            t_d        = '0;
                            comp_act_d = 1'b1;
`endif
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        bus.x_ready      = 1'b0;
        bus.xmem_wr_en   = 1'b0;
        bus.xmem_wr_addr = '0;
        bus.rd_en        = 1'b0;
        bus.rd_k         = '0;
        bus.rd_base      = '0;
        bus.mac_en       = 1'b0;
        bus.mac_clr      = 1'b0;
        bus.out_load     = 1'b0;
        bus.y_valid      = 1'b0;
        bus.y_sel        = '0;
        if (reset) begin
            bus.x_ready      = (state_q == LOAD);
            bus.xmem_wr_en   = x_acc;
            bus.xmem_wr_addr = ld_cnt_q;
            bus.rd_en        = rd_en_i;
            bus.rd_k         = rd_en_i ? t_q[KW-1:0] : '0;
`ifdef CONV_CTRL_OVERLAP_EN
            // while draining, reads belong to the following group
            bus.rd_base      = (state_q == DRAIN) ? (base_q + STEP) : base_q;
`else
            bus.rd_base      = base_q;
`endif
            bus.mac_en       = en_pipe_q[1];
            bus.mac_clr      = clr_pipe_q[1];
            bus.out_load     = (state_q == COMPUTE) && comp_done;
            bus.y_valid      = (state_q == DRAIN);
            bus.y_sel        = (state_q == DRAIN) ? lane_q : '0;
        end
    end
endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Directed bench for conv_layer_ctrl: N=64 instance for the main sequence,
// N=20 instance for the short last group. Honours CONV_CTRL_OVERLAP_EN.
module tb_conv_layer_ctrl;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

`ifdef CONV_CTRL_OVERLAP_EN
    localparam int EXP_LAT_A = 92;
    localparam int EXP_LAT_B = 28;
`else
    localparam int EXP_LAT_A = 140;
    localparam int EXP_LAT_B = 36;
`endif

    always #5 clk = ~clk;

    conv_layer_ctrl_if #(.N(64), .M(9), .P(8)) if_a ();
    conv_layer_ctrl_if #(.N(20), .M(9), .P(8)) if_b ();

    conv_layer_ctrl #(.N(64), .M(9), .P(8)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (if_a.master)
    );

    conv_layer_ctrl #(.N(20), .M(9), .P(8)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (if_b.master)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] ctl;
        if_a.x_valid = 1'b1;
        if_a.y_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #2;
            ctl = {if_a.x_ready, if_a.xmem_wr_en, if_a.rd_en, if_a.mac_en,
                   if_a.mac_clr, if_a.out_load, if_a.y_valid};
            checks++;
            if (ctl !== 7'b0 || if_a.xmem_wr_addr !== 6'd0 || if_a.y_sel !== 3'd0) begin
                errors++;
                $display("FAIL reset_outputs: ctl=%b addr=%0d sel=%0d, required all 0",
                         ctl, if_a.xmem_wr_addr, if_a.y_sel);
            end
        end
        if_a.x_valid = 1'b0;
        if_a.y_ready = 1'b0;
        rst_a = 1'b1;
        #1;
        checks++;
        if (if_a.x_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_x_ready: got %b required 1", if_a.x_ready);
        end
        next_cycle();
    endtask

    task automatic test_load();
        int acc = 0;
        int cyc = 0;
        while (acc < 64 && cyc < 2000) begin
            if_a.x_valid = 1'($urandom_range(0, 1));
            #1;
            if (if_a.xmem_wr_en === 1'b1) begin
                checks++;
                if (if_a.xmem_wr_addr !== 6'(acc)) begin
                    errors++;
                    $display("FAIL load_addr: got %0d required %0d", if_a.xmem_wr_addr, acc);
                end
                acc++;
            end
            cyc++;
            next_cycle();
        end
        checks++;
        if (acc !== 64) begin
            errors++;
            $display("FAIL load_count: got %0d accepts required 64 within budget", acc);
        end
        if_a.x_valid = 1'b1;
    endtask

    task automatic test_first_group();
        logic [3:0] tk;
        for (int t = 0; t < 12; t++) begin
            #1;
            tk = 4'(t);
            checks++;
            if (if_a.rd_en !== (t < 9)) begin
                errors++;
                $display("FAIL grp_rd_en t=%0d: got %b required %b", t, if_a.rd_en, (t < 9));
            end
            if (t < 9) begin
                checks++;
                if (if_a.rd_k !== tk || if_a.rd_base !== 6'd0) begin
                    errors++;
                    $display("FAIL grp_rd_addr t=%0d: k=%0d base=%0d required k=%0d base=0",
                             t, if_a.rd_k, if_a.rd_base, tk);
                end
            end
            checks++;
            if (if_a.mac_en !== (t >= 2 && t <= 10)) begin
                errors++;
                $display("FAIL grp_mac_en t=%0d: got %b", t, if_a.mac_en);
            end
            checks++;
            if (if_a.mac_clr !== (t == 2)) begin
                errors++;
                $display("FAIL grp_mac_clr t=%0d: got %b", t, if_a.mac_clr);
            end
            checks++;
            if (if_a.out_load !== (t == 11)) begin
                errors++;
                $display("FAIL grp_out_load t=%0d: got %b", t, if_a.out_load);
            end
            checks++;
            if (if_a.x_ready !== 1'b0 || if_a.xmem_wr_en !== 1'b0 || if_a.y_valid !== 1'b0) begin
                errors++;
                $display("FAIL grp_quiet t=%0d: x_ready=%b wr_en=%b y_valid=%b required 0",
                         t, if_a.x_ready, if_a.xmem_wr_en, if_a.y_valid);
            end
            next_cycle();
        end
        if_a.x_valid = 1'b0;
    endtask

    task automatic test_drain_stall();
        if_a.y_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (if_a.y_valid !== 1'b1 || if_a.y_sel !== 3'd0) begin
                errors++;
                $display("FAIL stall_hold i=%0d: y_valid=%b y_sel=%0d required 1/0",
                         i, if_a.y_valid, if_a.y_sel);
            end
`ifdef CONV_CTRL_OVERLAP_EN
            if (i == 0) begin
                checks++;
                if (if_a.rd_en !== 1'b1 || if_a.rd_k !== 4'd0 || if_a.rd_base !== 6'd8) begin
                    errors++;
                    $display("FAIL overlap_start: rd_en=%b k=%0d base=%0d required 1/0/8",
                             if_a.rd_en, if_a.rd_k, if_a.rd_base);
                end
            end
            if (i >= 11) begin
                checks++;
                if (if_a.mac_en !== 1'b0 || if_a.out_load !== 1'b0) begin
                    errors++;
                    $display("FAIL overlap_hold i=%0d: mac_en=%b out_load=%b required 0",
                             i, if_a.mac_en, if_a.out_load);
                end
            end
`endif
            next_cycle();
        end
        if_a.y_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (if_a.y_valid !== 1'b1 || if_a.y_sel !== 3'(i)) begin
                errors++;
                $display("FAIL drain_seq: y_valid=%b y_sel=%0d required 1/%0d",
                         if_a.y_valid, if_a.y_sel, i);
            end
            next_cycle();
        end
        if_a.y_ready = 1'b0;
        #1;
        checks++;
`ifdef CONV_CTRL_OVERLAP_EN
        if (if_a.out_load !== 1'b1 || if_a.y_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_drain: out_load=%b y_valid=%b required 1/0",
                     if_a.out_load, if_a.y_valid);
        end
`else
        if (if_a.y_valid !== 1'b0 || if_a.rd_en !== 1'b1 || if_a.rd_k !== 4'd0 ||
            if_a.rd_base !== 6'd8) begin
            errors++;
            $display("FAIL after_drain: y_valid=%b rd_en=%b k=%0d base=%0d required 0/1/0/8",
                     if_a.y_valid, if_a.rd_en, if_a.rd_k, if_a.rd_base);
        end
`endif
        next_cycle();
    endtask

    task automatic test_reset_in_drain();
        bit found = 1'b0;
        bit bad = 1'b0;
        if_a.y_ready = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            #1;
            if (if_a.y_valid === 1'b1 && if_a.y_sel === 3'd3) found = 1'b1;
            else next_cycle();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_drain_reach: got no y_sel=3 required within 100 cycles");
        end
        rst_a = 1'b0;
        #1;
        checks++;
        if (if_a.y_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_forced: y_valid=%b required 0", if_a.y_valid);
        end
        next_cycle();
        #1;
        checks++;
        if (if_a.y_valid !== 1'b0 || if_a.out_load !== 1'b0) begin
            errors++;
            $display("FAIL rst_next: y_valid=%b out_load=%b required 0",
                     if_a.y_valid, if_a.out_load);
        end
        rst_a = 1'b1;
        #1;
        checks++;
        if (if_a.x_ready !== 1'b1 || if_a.xmem_wr_addr !== 6'd0) begin
            errors++;
            $display("FAIL rst_release: x_ready=%b addr=%0d required 1/0",
                     if_a.x_ready, if_a.xmem_wr_addr);
        end
        next_cycle();
        for (int i = 0; i < 20; i++) begin
            #1;
            if (if_a.y_valid !== 1'b0 || if_a.out_load !== 1'b0 ||
                if_a.rd_en !== 1'b0 || if_a.mac_en !== 1'b0) bad = 1'b1;
            next_cycle();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rst_discard: got activity after reset, required none");
        end
    endtask

    task automatic test_latency();
        int acc = 0;
        int c = 0;
        int last = -1;
        int hs = 0;
        bit done = 1'b0;
        if_a.x_valid = 1'b1;
        if_a.y_ready = 1'b1;
        for (int i = 0; i < 200 && acc < 64; i++) begin
            #1;
            if (if_a.xmem_wr_en === 1'b1) acc++;
            next_cycle();
        end
        if_a.x_valid = 1'b0;
        while (!done && c < 2000) begin
            #1;
            if (if_a.y_valid === 1'b1) begin
                hs++;
                last = c;
            end
            if (if_a.x_ready === 1'b1) done = 1'b1;
            else begin
                c++;
                next_cycle();
            end
        end
        checks++;
        if (!done || acc !== 64) begin
            errors++;
            $display("FAIL lat_timeout: acc=%0d done=%b required 64/1", acc, done);
        end
        checks++;
        if (hs !== 56) begin
            errors++;
            $display("FAIL lat_handshakes: got %0d required 56", hs);
        end
        checks++;
        if (last + 1 !== EXP_LAT_A) begin
            errors++;
            $display("FAIL lat_cycles: got %0d required %0d", last + 1, EXP_LAT_A);
        end
        checks++;
        if (c !== last + 1) begin
            errors++;
            $display("FAIL lat_reload: LOAD at %0d required %0d", c, last + 1);
        end
    endtask

    task automatic test_short_vector();
        int acc = 0;
        int c = 0;
        int last = -1;
        int hs = 0;
        int loads = 0;
        bit done = 1'b0;
        bit bad_base = 1'b0;
        logic [2:0] es;
        rst_b = 1'b1;
        #1;
        checks++;
        if (if_b.x_ready !== 1'b1) begin
            errors++;
            $display("FAIL short_x_ready: got %b required 1", if_b.x_ready);
        end
        next_cycle();
        if_b.x_valid = 1'b1;
        if_b.y_ready = 1'b1;
        for (int i = 0; i < 100 && acc < 20; i++) begin
            #1;
            if (if_b.xmem_wr_en === 1'b1) begin
                checks++;
                if (if_b.xmem_wr_addr !== 5'(acc)) begin
                    errors++;
                    $display("FAIL short_addr: got %0d required %0d", if_b.xmem_wr_addr, acc);
                end
                acc++;
            end
            next_cycle();
        end
        if_b.x_valid = 1'b0;
        while (!done && c < 1000) begin
            #1;
            if (if_b.rd_en === 1'b1 && if_b.rd_base !== 5'(8 * loads)) bad_base = 1'b1;
            if (if_b.out_load === 1'b1) loads++;
            if (if_b.y_valid === 1'b1) begin
                es = 3'((hs < 8) ? hs : hs - 8);
                checks++;
                if (if_b.y_sel !== es) begin
                    errors++;
                    $display("FAIL short_y_sel hs=%0d: got %0d required %0d", hs, if_b.y_sel, es);
                end
                hs++;
                last = c;
            end
            if (if_b.x_ready === 1'b1) done = 1'b1;
            else begin
                c++;
                next_cycle();
            end
        end
        checks++;
        if (!done || hs !== 12 || acc !== 20) begin
            errors++;
            $display("FAIL short_count: hs=%0d acc=%0d done=%b required 12/20/1", hs, acc, done);
        end
        checks++;
        if (last + 1 !== EXP_LAT_B || c !== last + 1) begin
            errors++;
            $display("FAIL short_timing: last=%0d load=%0d required %0d/%0d",
                     last + 1, c, EXP_LAT_B, EXP_LAT_B);
        end
        checks++;
        if (bad_base || loads !== 2) begin
            errors++;
            $display("FAIL short_base: bad_base=%b loads=%0d required 0/2", bad_base, loads);
        end
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        if_a.x_valid = 1'b0;
        if_a.y_ready = 1'b0;
        if_b.x_valid = 1'b0;
        if_b.y_ready = 1'b0;
        test_reset();
        test_load();
        test_first_group();
        test_drain_stall();
        test_reset_in_drain();
        test_latency();
        test_short_vector();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_layer_ctrl.md
# conv_layer_ctrl

Sequencing controller for one 1-D convolution layer of the `net_*` accelerator.
- Accepts an N-word input vector over a valid/ready stream into the layer's x-memory.
- Steps a P-lane MAC datapath through all N−M+1 outputs, P at a time, using a read-only filter memory.
- Drains each lane's result over a valid/ready output stream with a lane-select.
- Contains no arithmetic: it drives addresses, enables and handshakes for the sibling memory/MAC datapath. One instance per layer in the `net_*` top level.

## Interface
Parameters:
- `N`, 64, input vector length
- `M`, 9, filter length
- `P`, 8, MAC lanes (outputs per group)
- `NOUT`, N−M+1 (derived, localparam), outputs per vector

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low (0 = reset); one clock, synchronous active-low reset
- `x_valid`  in  1  upstream word valid
- `x_ready`  out  1  controller accepts a word this cycle
- `xmem_wr_en`  out  1  write x-memory (= `x_valid && x_ready`)
- `xmem_wr_addr`  out  $clog2(N)  write address = load count
- `rd_en`  out  1  read x-memory and filter memory this cycle
- `rd_k`  out  $clog2(M)  filter tap; lane p reads x[`rd_base`+p+`rd_k`]
- `rd_base`  out  $clog2(N)  first output index of the current group
- `mac_en`  out  1  lanes accumulate
- `mac_clr`  out  1  with `mac_en`: acc = product (first tap)
- `out_load`  out  1  capture lane accumulators into output registers
- `y_valid`  out  1  output word valid
- `y_ready`  in  1  downstream accepts
- `y_sel`  out  $clog2(P)  lane driven onto `y_data` by the datapath

## Operation
- States: LOAD, COMPUTE, DRAIN. Counters: `ld_cnt` (0..N−1), `k_cnt`, `base` (steps of P), `lane`.
- LOAD:
  - `x_ready`=1.
  - Each `x_valid && x_ready` writes `xmem_wr_addr`=`ld_cnt`, then increments `ld_cnt`.
  - On the N-th accept: `ld_cnt`←0, `base`←0, next state COMPUTE.
- COMPUTE, entry cycle t=0:
  - t=0..M−1: `rd_en`=1, `rd_k`=t, `rd_base`=`base`.
  - `mac_en` = `rd_en` delayed 2 cycles (1 memory, 1 multiplier register); `mac_clr` = (`rd_k`==0) delayed identically.
  - `out_load` is a 1-cycle pulse at t=M+2. Next state DRAIN.
- DRAIN:
  - `y_valid`=1, `y_sel`=`lane`.
  - Lanes to drain: L = min(P, NOUT−`base`).
  - On each `y_valid && y_ready`, `lane`++. After lane L−1 is accepted: `lane`←0, `base`←`base`+P.
  - Then next state is COMPUTE if `base`+P < NOUT, else LOAD.
- `y_valid` never deasserts without a handshake. `y_sel` is stable while `y_valid && !y_ready`.
- Address widths: `rd_base`+P−1+`rd_k` ≤ N−1 for every valid lane. The datapath ignores lanes ≥ L.

## Timing
- All state/counters are registered. Outputs are decoded from registered state only (no combinational `y_ready`→`y_valid` or `x_valid`→`x_ready` path). Sole exception: `xmem_wr_en` is ANDed with `x_valid`.
- Reset:
  - Any cycle with `reset`=0 sampled: state←LOAD, all counters←0, delay pipes cleared.
  - While `reset`=0, all outputs are forced to 0, including `x_ready`.
  - `x_ready`=1 from the first cycle with `reset`=1.
  - Reset mid-COMPUTE/DRAIN discards the group. No `out_load` or `y_valid` follows.
- Group latency without overlap: M+3 cycles COMPUTE + L accepted handshakes.
- LOAD of the next vector starts the cycle after the last DRAIN handshake.

## Configuration
- `CONV_CTRL_OVERLAP_EN` undefined: behaviour as above, fully serial.
- `CONV_CTRL_OVERLAP_EN` defined: next-group COMPUTE overlaps current DRAIN.
  - On entering DRAIN for group g (g not last), the read/MAC sequence for g+1 starts in the same cycle.
  - The `out_load` for g+1 fires at the first cycle that satisfies both: its t≥M+2, and the drain of g has completed. Until then, `mac_en`=0 and accumulators hold.
  - LOAD still waits for the last drain.

## Test plan
- Reset low 2 cycles, then 64 words with random `x_valid` → exactly 64 `xmem_wr_en` pulses, addresses 0..63 in order; `x_ready`=0 the cycle after the 64th accept.
- First group (N=64, M=9, P=8) → `rd_k` 0..8 with `rd_base`=0 on t=0..8; `mac_en` t=2..10 with `mac_clr` only at t=2; `out_load` at t=11.
- `y_ready` held 0 for 20 cycles in DRAIN → `y_valid`=1 and `y_sel`=0 throughout, no counter change; release → `y_sel` 0..7 on consecutive cycles.
- N=20, M=9, P=8 (NOUT=12) → group `base`=8 drains only 4 lanes (`y_sel` 0..3), then `x_ready`=1.
- Reset asserted during DRAIN at `y_sel`=3 → next cycle `y_valid`=0; after release `x_ready`=1, `xmem_wr_addr`=0.
- `y_ready`=1 constantly, N=64, M=9, P=8 → COMPUTE entry to last output handshake is 140 cycles without the macro and 92 cycles with `CONV_CTRL_OVERLAP_EN`; 56 handshakes either way.
